dawson_if: RTL and testbench

- Wrapper between a simple user request/response port and a Dawson-style floating-point unit that uses a strobe/acknowledge (stb/ack) handshake.
- Captures operands a and b on a user request and presents them to the unit with input strobes.
- Collects the result with an output ack and returns it to the user with a one-cycle ready_out pulse.
- Also drives the unit's clock and reset.

---
 rtl/dawson_if_pkg.sv | 16 +
 rtl/dawson_if.sv | 137 +++++++++++++
 tb/tb_dawson_if.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dawson_if_pkg.sv
// Shared types for the Dawson FPU request/response wrapper: FSM state encoding
// and the default datapath width.
package dawson_if_pkg;

    localparam int DEFAULT_WIDTH = 64;

    typedef enum logic [2:0] {
        ST_RESET   = 3'd0,
        ST_IDLE    = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_RECEIVE = 3'd4,
        ST_RX_USER = 3'd5
    } state_t;

endpackage

// File: rtl/dawson_if.sv
// Bridges a user request/ready port to a Dawson-style FPU stb/ack handshake.
// Optional macro DAWSON_IF_BUSY_EN adds a registered busy output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | holding the unit in reset; leaves on the first clock
// IDLE     | waiting for ready_in, operands latched on request
// WAIT_TX  | strobing operands until both A and B have been acked
// WAIT_RX  | waiting for the unit's output_z_stb
// RECEIVE  | output_z_ack high for one cycle, result captured
// RX_USER  | ready_out pulse to the user, then back to IDLE
module dawson_if
    import dawson_if_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ready_in,
    output logic [WIDTH-1:0] out,
    output logic             ready_out,
`ifdef DAWSON_IF_BUSY_EN
    output logic             busy,
`endif
    output logic             clk,
    output logic             rst,
    output logic [WIDTH-1:0] input_a,
    output logic [WIDTH-1:0] input_b,
    output logic             input_a_stb,
    output logic             input_b_stb,
    output logic             output_z_ack,
    input  logic [WIDTH-1:0] output_z,
    input  logic             output_z_stb,
    input  logic             input_a_ack,
    input  logic             input_b_ack
);

    state_t state;
    logic   a_done;
    logic   b_done;
    logic   a_fin;
    logic   b_fin;

    assign clk = clock;
    assign rst = !reset_n || (state == ST_RESET);

    // An operand counts as delivered once acked, including an ack on this very clock.
    assign a_fin = a_done || (input_a_stb && input_a_ack);
    assign b_fin = b_done || (input_b_stb && input_b_ack);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_RESET;
            input_a      <= '0;
            input_b      <= '0;
            out          <= '0;
            input_a_stb  <= 1'b0;
            input_b_stb  <= 1'b0;
            output_z_ack <= 1'b0;
            ready_out    <= 1'b0;
            a_done       <= 1'b0;
            b_done       <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (ready_in) begin
                        input_a     <= a;
                        input_b     <= b;
                        input_a_stb <= 1'b1;
                        input_b_stb <= 1'b1;
                        a_done      <= 1'b0;
                        b_done      <= 1'b0;
                        state       <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    if (input_a_stb && input_a_ack) begin
                        input_a_stb <= 1'b0;
                        a_done      <= 1'b1;
                    end
                    if (input_b_stb && input_b_ack) begin
                        input_b_stb <= 1'b0;
                        b_done      <= 1'b1;
                    end
                    if (a_fin && b_fin) begin
                        input_a_stb <= 1'b0;
                        input_b_stb <= 1'b0;
                        state       <= ST_WAIT_RX;
                    end
                end
                ST_WAIT_RX: begin
                    output_z_ack <= 1'b0;
                    if (output_z_stb) begin
                        output_z_ack <= 1'b1;
                        state        <= ST_RECEIVE;
                    end
                end
                ST_RECEIVE: begin
                    out          <= output_z;
                    output_z_ack <= 1'b0;
                    ready_out    <= 1'b1;
                    state        <= ST_RX_USER;
                end
                ST_RX_USER: begin
                    ready_out <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

`ifdef DAWSON_IF_BUSY_EN
    // busy reflects the state being entered, so it lines up with the other registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE:    busy <= ready_in;
                ST_WAIT_TX: busy <= 1'b1;
                ST_WAIT_RX: busy <= 1'b1;
                ST_RECEIVE: busy <= 1'b1;
                default:    busy <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_dawson_if.sv
// Self-checking bench for dawson_if: directed vector table, hand-written corner
// sequences, and randomized transactions checked against a timing model.
module tb_dawson_if;
    localparam int W = 64;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] a = '0, b = '0, output_z = '0;
    logic         ready_in = 1'b0, output_z_stb = 1'b0, input_a_ack = 1'b0, input_b_ack = 1'b0;
    logic [W-1:0] out, input_a, input_b;
    logic         ready_out, clk, rst, input_a_stb, input_b_stb, output_z_ack;
`ifdef DAWSON_IF_BUSY_EN
    logic         busy;
`endif

    int checks = 0;
    int errors = 0;

    dawson_if #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .a(a), .b(b), .ready_in(ready_in),
        .out(out), .ready_out(ready_out),
`ifdef DAWSON_IF_BUSY_EN
        .busy(busy),
`endif
        .clk(clk), .rst(rst), .input_a(input_a), .input_b(input_b),
        .input_a_stb(input_a_stb), .input_b_stb(input_b_stb), .output_z_ack(output_z_ack),
        .output_z(output_z), .output_z_stb(output_z_stb),
        .input_a_ack(input_a_ack), .input_b_ack(input_b_ack)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic sa, input logic sb, input logic za,
                            input logic rd, input logic bz, input logic [W-1:0] ia,
                            input logic [W-1:0] ib, input logic [W-1:0] o);
        chk({tag, " input_a_stb"}, W'(input_a_stb), W'(sa));
        chk({tag, " input_b_stb"}, W'(input_b_stb), W'(sb));
        chk({tag, " output_z_ack"}, W'(output_z_ack), W'(za));
        chk({tag, " ready_out"}, W'(ready_out), W'(rd));
        chk({tag, " input_a"}, input_a, ia);
        chk({tag, " input_b"}, input_b, ib);
        chk({tag, " out"}, out, o);
        chk({tag, " rst"}, W'(rst), W'(0));
        chk({tag, " clk"}, W'(clk), W'(clock));
`ifdef DAWSON_IF_BUSY_EN
        chk({tag, " busy"}, W'(busy), W'(bz));
`else
        if (bz === 1'bx) errors++;
`endif
    endtask

    task automatic drv(input logic rin, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic aa, input logic ab, input logic zs, input logic [W-1:0] z);
        ready_in = rin; a = va; b = vb;
        input_a_ack = aa; input_b_ack = ab; output_z_stb = zs; output_z = z;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    typedef struct {
        logic         rin;
        logic [W-1:0] va, vb;
        logic         aa, ab, zs;
        logic [W-1:0] z;
        logic         sa, sb, za, rd, bz;
        logic [W-1:0] ia, ib, o;
    } vec_t;

    vec_t vecs[14];

    logic [W-1:0] prev_out;
    logic [W-1:0] a_op, b_op, z_op;
    int           da, db, dz, m, lat;

    initial begin
        // rin va vb aa ab zs z | sa sb za rd bz ia ib out
        vecs[0]  = '{1, 1, 2, 0, 0, 0, 0,      1, 1, 0, 0, 1, 1, 2, 0};
        vecs[1]  = '{0, 9, 9, 0, 0, 0, 0,      1, 1, 0, 0, 1, 1, 2, 0};
        vecs[2]  = '{0, 9, 9, 1, 1, 0, 0,      0, 0, 0, 0, 1, 1, 2, 0};
        vecs[3]  = '{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 2, 0};
        vecs[4]  = '{1, 4, 4, 0, 0, 0, 0,      0, 0, 0, 0, 1, 1, 2, 0};
        vecs[5]  = '{0, 0, 0, 1, 0, 0, 0,      0, 0, 0, 0, 1, 1, 2, 0};
        vecs[6]  = '{1, 4, 4, 0, 0, 1, 3,      0, 0, 1, 0, 1, 1, 2, 0};
        vecs[7]  = '{1, 4, 4, 0, 0, 0, 3,      0, 0, 0, 1, 1, 1, 2, 3};
        vecs[8]  = '{1, 5, 7, 0, 0, 0, 0,      0, 0, 0, 0, 0, 1, 2, 3};
        vecs[9]  = '{1, 5, 7, 0, 0, 0, 0,      1, 1, 0, 0, 1, 5, 7, 3};
        vecs[10] = '{0, 0, 0, 1, 1, 0, 0,      0, 0, 0, 0, 1, 5, 7, 3};
        vecs[11] = '{0, 0, 0, 0, 0, 1, 'hAAAA, 0, 0, 1, 0, 1, 5, 7, 3};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 'hAAAA, 0, 0, 0, 1, 1, 5, 7, 'hAAAA};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 0,      0, 0, 0, 0, 0, 5, 7, 'hAAAA};

        // Reset: asserted from time 0, released at 1 ns, first clock at 5 ns.
        #1;
        chk("reset rst", W'(rst), W'(1));
        chk("reset clk lo", W'(clk), W'(clock));
        chk("reset out", out, '0);
        chk("reset input_a", input_a, '0);
        chk("reset stb/ack/rdy", W'({input_a_stb, input_b_stb, output_z_ack, ready_out}), '0);
        reset_n = 1'b1;
        #1;
        chk("rst before first clock", W'(rst), W'(1));
        #5;
        chk("clk hi", W'(clk), W'(clock));
        @(negedge clock);
        chk_outs("after reset", 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drv(vecs[i].rin, vecs[i].va, vecs[i].vb, vecs[i].aa, vecs[i].ab, vecs[i].zs, vecs[i].z);
            tick();
            chk_outs($sformatf("vec%0d", i), vecs[i].sa, vecs[i].sb, vecs[i].za, vecs[i].rd,
                     vecs[i].bz, vecs[i].ia, vecs[i].ib, vecs[i].o);
        end

        // Split acks: A acked first, B two clocks later; stale A ack and early z_stb ignored.
        drv(1, 'h11, 'h22, 0, 0, 0, 0);   tick(); chk_outs("split req", 1, 1, 0, 0, 1, 'h11, 'h22, 'hAAAA);
        drv(0, 0, 0, 1, 0, 0, 0);         tick(); chk_outs("split ackA", 0, 1, 0, 0, 1, 'h11, 'h22, 'hAAAA);
        drv(0, 0, 0, 1, 0, 1, 'h33);      tick(); chk_outs("split wait", 0, 1, 0, 0, 1, 'h11, 'h22, 'hAAAA);
        drv(0, 0, 0, 0, 1, 1, 'h33);      tick(); chk_outs("split ackB", 0, 0, 0, 0, 1, 'h11, 'h22, 'hAAAA);
        drv(0, 0, 0, 0, 0, 1, 'h33);      tick(); chk_outs("split zack", 0, 0, 1, 0, 1, 'h11, 'h22, 'hAAAA);
        drv(0, 0, 0, 0, 0, 0, 'h33);      tick(); chk_outs("split rdy", 0, 0, 0, 1, 1, 'h11, 'h22, 'h33);
        drv(0, 0, 0, 0, 0, 0, 0);         tick(); chk_outs("split idle", 0, 0, 0, 0, 0, 'h11, 'h22, 'h33);

        // Reset while waiting for the result: abort, no late ready_out.
        drv(1, 'h44, 'h55, 0, 0, 0, 0);   tick();
        drv(0, 0, 0, 1, 1, 0, 0);         tick();
        drv(0, 0, 0, 0, 0, 0, 0);         tick(); chk_outs("pre-abort", 0, 0, 0, 0, 1, 'h44, 'h55, 'h33);
        reset_n = 1'b0;
        #1;
        chk("abort rst", W'(rst), W'(1));
        chk("abort out", out, '0);
        chk("abort input_a", input_a, '0);
        chk("abort stb/ack/rdy", W'({input_a_stb, input_b_stb, output_z_ack, ready_out}), '0);
        #2;
        reset_n = 1'b1;
        drv(0, 0, 0, 0, 0, 1, 'h99);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_outs($sformatf("post-abort%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        prev_out = '0;

        // Random transactions; ready_out lands 3 + max(da,db) + dz clocks after the request.
        for (int t = 0; t < 40; t++) begin
            a_op = {$urandom, $urandom};
            b_op = {$urandom, $urandom};
            z_op = {$urandom, $urandom};
            da = $urandom_range(0, 3);
            db = $urandom_range(0, 3);
            dz = $urandom_range(0, 3);
            m = (da > db) ? da : db;
            lat = 3 + m + dz;
            drv(1, a_op, b_op, 0, 0, 0, {$urandom, $urandom});
            tick();
            chk_outs($sformatf("rnd%0d req", t), 1, 1, 0, 0, 1, a_op, b_op, prev_out);
            for (int n = 1; n <= lat + 1; n++) begin
                ready_in = 1'($urandom_range(0, 1));
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                input_a_ack = (n == 1 + da) || (n > 1 + da && $urandom_range(0, 1) == 1);
                input_b_ack = (n == 1 + db) || (n > 1 + db && $urandom_range(0, 1) == 1);
                output_z_stb = (n == 2 + m + dz);
                output_z = (n >= 2 + m + dz && n <= lat) ? z_op : {$urandom, $urandom};
                tick();
                chk_outs($sformatf("rnd%0d n%0d", t, n), n <= da, n <= db, n == 2 + m + dz,
                         n == lat, n <= lat, a_op, b_op, (n >= lat) ? z_op : prev_out);
            end
            drv(0, 0, 0, 0, 0, 0, 0);
            tick();
            chk_outs($sformatf("rnd%0d idle", t), 0, 0, 0, 0, 0, a_op, b_op, z_op);
            prev_out = z_op;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1);
    end
endmodule
